mul_iter: RTL and testbench

- Iterative 32x32 radix-2 shift-add multiplier; the multiply counterpart of the team's iterative divider.
- Sits beside the divider in the execute-stage multi-cycle unit.
- Uses the same valid/finish handshake and sign-magnitude flow: take operand absolute values, iterate, then sign-fix.
- Produces a full 2*WIDTH-bit product split into hi/lo halves.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_neg.sv | 22 ++
 rtl/mul_iter.sv | 144 ++++++++++++++
 tb/tb_mul_iter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// =============================================================================
// Module   : mul_pkg
// Brief    : Shared constants for the iterative shift-add multiplier.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package mul_pkg;

    localparam int c_WIDTH   = 32;
    localparam int c_STATE_W = 5;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 5'b00001;
    localparam logic [c_STATE_W-1:0] c_ST_INIT = 5'b00010;
    localparam logic [c_STATE_W-1:0] c_ST_CALC = 5'b00100;
    localparam logic [c_STATE_W-1:0] c_ST_FIX  = 5'b01000;
    localparam logic [c_STATE_W-1:0] c_ST_DONE = 5'b10000;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_neg.sv
// =============================================================================
// Module   : mul_neg
// Brief    : Conditional two's-complement negate (o_out = i_en ? -i_in : i_in).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module mul_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_out
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign o_out = i_en ? (~i_in + c_ONE) : i_in;

endmodule

`default_nettype wire

// File: rtl/mul_iter.sv
// =============================================================================
// Module   : mul_iter
// Brief    : Iterative radix-2 shift-add multiplier, sign-magnitude flow,
//            valid/finish handshake. Optional macro MUL_EARLY_TERM_EN ends
//            the iteration once the remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             sign,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             finish
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_CNT_W = cnt_width(WIDTH);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    logic [c_PW-1:0]    r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [c_PW-1:0]    r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sign;
    logic               r_neg;

    logic [WIDTH-1:0] w_x_abs;
    logic [WIDTH-1:0] w_y_abs;
    logic [c_PW-1:0]  w_acc_fix;
    logic             w_calc_last;

    // Raw operands are parked in mcand/mplr in IDLE and made absolute in INIT.
    mul_neg #(.WIDTH(WIDTH)) u_neg_x (
        .i_in  (r_mcand[WIDTH-1:0]),
        .i_en  (r_sign & r_mcand[WIDTH-1]),
        .o_out (w_x_abs)
    );

    mul_neg #(.WIDTH(WIDTH)) u_neg_y (
        .i_in  (r_mplr),
        .i_en  (r_sign & r_mplr[WIDTH-1]),
        .o_out (w_y_abs)
    );

    mul_neg #(.WIDTH(c_PW)) u_neg_acc (
        .i_in  (r_acc),
        .i_en  (r_neg),
        .o_out (w_acc_fix)
    );

`ifdef MUL_EARLY_TERM_EN
    assign w_calc_last = (r_cnt == c_CNT_ONE) || (r_mplr[WIDTH-1:1] == '0);
`else
    assign w_calc_last = (r_cnt == c_CNT_ONE);
`endif

    assign finish = (r_state == c_ST_DONE);

    always_comb begin
        w_next_state = r_state;
        if (!valid) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: w_next_state = c_ST_INIT;
                c_ST_INIT: w_next_state = c_ST_CALC;
                c_ST_CALC: w_next_state = w_calc_last ? c_ST_FIX : c_ST_CALC;
                c_ST_FIX:  w_next_state = c_ST_DONE;
                default:   w_next_state = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dropping valid anywhere behaves like a reset of the datapath.
    always_ff @(posedge clk) begin
        if (rst || !valid) begin
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_neg     <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_mcand <= {{WIDTH{1'b0}}, x};
                    r_mplr  <= y;
                    r_sign  <= sign;
                end
                c_ST_INIT: begin
                    r_mcand <= {{WIDTH{1'b0}}, w_x_abs};
                    r_mplr  <= w_y_abs;
                    r_acc   <= '0;
                    r_cnt   <= c_CNT_INIT;
                    r_neg   <= r_sign & (r_mcand[WIDTH-1] ^ r_mplr[WIDTH-1]);
                end
                c_ST_CALC: begin
                    if (r_mplr[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= {r_mcand[c_PW-2:0], 1'b0};
                    r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
                    r_cnt   <= r_cnt - c_CNT_ONE;
                end
                c_ST_FIX: begin
                    // Results load here so they are already valid during DONE.
                    r_acc     <= w_acc_fix;
                    result_hi <= w_acc_fix[c_PW-1:WIDTH];
                    result_lo <= w_acc_fix[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_iter.sv
// =============================================================================
// Module   : tb_mul_iter
// Brief    : Self-checking bench for mul_iter (vector table, random ops,
//            abort / reset / back-to-back sequences). Honours MUL_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mul_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         sign;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic         finish;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    mul_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .sign      (sign),
        .x         (x),
        .y         (y),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .finish    (finish)
    );

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                input logic [W-1:0] hi, input logic [W-1:0] lo, input string n);
        vec_t v;
        v.x = a; v.y = b; v.s = s; v.hi = hi; v.lo = lo; v.name = n;
        return v;
    endfunction

    // Full-width product by plain 64-bit arithmetic on extended operands.
    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b, input logic s);
`ifdef MUL_EARLY_TERM_EN
        logic [W-1:0] m;
        int top;
        m   = (s && b[31]) ? (~b + 32'd1) : b;
        top = 0;
        for (int i = 0; i < W; i++) if (m[i]) top = i + 1;
        return 3 + ((top < 1) ? 1 : top);
`else
        return (b === b) ? W + 3 : W + 3;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts an op from IDLE and waits (bounded) for finish.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit scramble, output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output int lat);
        x = a; y = b; sign = s; valid = 1'b1;
        lat = -1; hi = '0; lo = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); @(negedge clk);
            if (scramble) begin
                x = $urandom; y = $urandom; sign = 1'($urandom_range(0, 1));
            end
            if (finish) begin
                lat = n; hi = result_hi; lo = result_lo;
                break;
            end
        end
    endtask

    // Keeps valid through DONE, checks hold in the following IDLE cycle, then clears.
    task automatic end_op(input logic [W-1:0] ehi, input logic [W-1:0] elo, input string name);
        @(posedge clk); @(negedge clk);
        check({name, " hold"}, {result_hi, result_lo}, {ehi, elo});
        valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check({name, " clear"}, {31'b0, finish, result_hi, result_lo} , 64'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit scramble, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input string name);
        logic [W-1:0] hi, lo;
        int lat;
        run_op(a, b, s, scramble, hi, lo, lat);
        check({name, " product"}, {hi, lo}, {ehi, elo});
        check({name, " latency"}, 64'(lat), 64'(ref_lat(b, s)));
        end_op(ehi, elo, name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hi, lo, a, b;
        logic [63:0]  p;
        logic         s;
        int           lat;
        bit           saw_finish;

        tbl[0]  = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, "umax");
        tbl[1]  = mk(32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, "neg3x7");
        tbl[2]  = mk(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, "smin2");
        tbl[3]  = mk(32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, "umin2");
        tbl[4]  = mk(32'h00000006, 32'h00000007, 1'b0, 32'h00000000, 32'h0000002A, "6x7");
        tbl[5]  = mk(32'h00000003, 32'h00000005, 1'b0, 32'h00000000, 32'h0000000F, "3x5");
        tbl[6]  = mk(32'h00000005, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, "y0");
        tbl[7]  = mk(32'h00000000, 32'h00000005, 1'b1, 32'h00000000, 32'h00000000, "x0");
        tbl[8]  = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, "m1m1");
        tbl[9]  = mk(32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000, "smin1");
        tbl[10] = mk(32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000, "u2p32");
        tbl[11] = mk(32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000, "smaxmin");

        rst = 1'b1; valid = 1'b0; sign = 1'b0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {31'b0, finish, result_hi, result_lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].x, tbl[i].y, tbl[i].s, 1'b0, tbl[i].hi, tbl[i].lo, tbl[i].name);
        end

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            s = 1'($urandom_range(0, 1));
            p = ref_prod(a, b, s);
            do_op(a, b, s, (i % 2) == 1, p[63:32], p[31:0], $sformatf("rand%0d", i));
        end

        // Back-to-back start, then abort the second op at cycle 10.
        run_op(32'h00012345, 32'h00000100, 1'b0, 1'b0, hi, lo, lat);
        check("b2b first product", {hi, lo}, 64'h0000000001234500);
        x = 32'd9; y = 32'h80000001; sign = 1'b0;
        @(posedge clk);
        saw_finish = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (finish) saw_finish = 1'b1;
        end
        check("b2b held result", {result_hi, result_lo}, 64'h0000000001234500);
        valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort clears", {31'b0, finish, result_hi, result_lo}, 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (finish) saw_finish = 1'b1;
        end
        check("abort no finish", 64'(saw_finish), 64'd0);
        do_op(32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 32'd42, "post-abort");

        // Back-to-back start, then synchronous reset at cycle 20.
        run_op(32'hDEADBEEF, 32'h00000010, 1'b0, 1'b0, hi, lo, lat);
        check("rst first product", {hi, lo}, 64'h0000000DEADBEEF0);
        x = 32'h0000FFFF; y = 32'hFFFF0000; sign = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid-op reset", {31'b0, finish, result_hi, result_lo}, 64'd0);
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        do_op(32'hFFFFFFF0, 32'h00000003, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFD0, "post-reset");
        do_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1,
              ref_prod(32'h12345678, 32'h9ABCDEF0, 1'b1) >> 32,
              ref_prod(32'h12345678, 32'h9ABCDEF0, 1'b1) & 64'hFFFFFFFF, "scrambled");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
